// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - two-requester round-robin arbiter onto one AXI slave
module axi_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [7:0]            req0_len,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_wready,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_rvalid,
  output logic                  req0_rlast,
  output logic                  req0_done,
  output logic [1:0]            req0_resp,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [7:0]            req1_len,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_wready,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_rvalid,
  output logic                  req1_rlast,
  output logic                  req1_done,
  output logic [1:0]            req1_resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic                  rlast
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t                  state;
  logic                    gnt;
  logic                    last_gnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat;
  logic [1:0]              resp0_q;
  logic [1:0]              resp1_q;
  logic                    grant_any;
  logic                    grant_sel;
  logic                    sel_write;
  logic                    in_r;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = req1_valid & (~req0_valid | ~last_gnt);
    sel_write = grant_sel ? req1_write : req0_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      addr_q   <= '0;
      len_q    <= '0;
      beat     <= '0;
      resp0_q  <= 2'b00;
      resp1_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            gnt    <= grant_sel;
            addr_q <= grant_sel ? req1_addr : req0_addr;
            len_q  <= grant_sel ? req1_len : req0_len;
            beat   <= '0;
            state  <= sel_write ? AW : AR;
          end
        end
        AW: if (awready) state <= W;
        W: begin
          if (wready) begin
            // Wraps harmlessly after the 256th beat of a len=255 burst.
            beat <= beat + 8'd1;
            if (beat == len_q) state <= B;
          end
        end
        B: begin
          if (bvalid) begin
            if (gnt) resp1_q <= bresp;
            else     resp0_q <= bresp;
            state <= DONE;
          end
        end
        AR: if (arready) state <= R;
        R: begin
          if (rvalid && rlast) begin
            if (gnt) resp1_q <= 2'b00;
            else     resp0_q <= 2'b00;
            state <= DONE;
          end
        end
        DONE: begin
          last_gnt <= gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_r        = (state == R);
    req0_ready  = (state == IDLE) && grant_any && !grant_sel;
    req1_ready  = (state == IDLE) && grant_sel;
    awvalid     = (state == AW);
    awaddr      = addr_q;
    awlen       = len_q;
    arvalid     = (state == AR);
    araddr      = addr_q;
    arlen       = len_q;
    wvalid      = (state == W);
    wdata       = wvalid ? (gnt ? req1_wdata : req0_wdata) : '0;
    wlast       = wvalid && (beat == len_q);
    bready      = (state == B);
    rready      = in_r;
    req0_wready = wvalid && !gnt && wready;
    req1_wready = wvalid && gnt && wready;
    req0_rvalid = in_r && !gnt && rvalid;
    req1_rvalid = in_r && gnt && rvalid;
    req0_rlast  = in_r && !gnt && rlast;
    req1_rlast  = in_r && gnt && rlast;
    req0_rdata  = (in_r && !gnt) ? rdata : '0;
    req1_rdata  = (in_r && gnt) ? rdata : '0;
    req0_done   = (state == DONE) && !gnt;
    req1_done   = (state == DONE) && gnt;
    req0_resp   = resp0_q;
    req1_resp   = resp1_q;
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - scoreboard bench for axi_mem_arbiter
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_write, req0_ready, req0_wready, req0_rvalid, req0_rlast, req0_done;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic [7:0]  req0_len;
  logic [1:0]  req0_resp;
  logic        req1_valid, req1_write, req1_ready, req1_wready, req1_rvalid, req1_rlast, req1_done;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic [7:0]  req1_len;
  logic [1:0]  req1_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_ready(req0_ready), .req0_wdata(req0_wdata), .req0_wready(req0_wready),
    .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid), .req0_rlast(req0_rlast),
    .req0_done(req0_done), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_ready(req1_ready), .req1_wdata(req1_wdata), .req1_wready(req1_wready),
    .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid), .req1_rlast(req1_rlast),
    .req1_done(req1_done), .req1_resp(req1_resp),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
  } txn_t;

  txn_t        q_txn[2][$];
  logic [31:0] q_wd[2][$];
  logic [31:0] q_rd[2][$];
  int          q_order[$];
  int          bc[2];
  int          wr_idx[2];
  logic        hs_pend[2];
  int          owner = 0;
  int          checks = 0;
  int          failures = 0;

  logic [1:0]  sl_bresp = 2'b00;
  logic        w_toggle = 1'b0;
  logic        b_pend = 1'b0;
  int          r_rem = 0;
  int          r_idx = 0;
  logic [31:0] r_addr = '0;

  function automatic logic [31:0] wbase(input int n);
    return (n == 1) ? 32'hB100_0000 : 32'hA000_0000;
  endfunction

  function automatic logic [31:0] rpat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=absent required=present", nm);
  endtask

  // AXI slave model: decisions made on the falling edge, handshakes land on the next rising edge.
  initial begin
    awready = 1'b0; arready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      awready = 1'b1;
      arready = 1'b1;
      bvalid  = b_pend;
      bresp   = b_pend ? sl_bresp : 2'b00;
      if (bvalid && bready) b_pend = 1'b0;
      wready = w_toggle ? ~wready : 1'b1;
      if (wvalid && wready && wlast) b_pend = 1'b1;
      if (arvalid) begin
        r_rem  = int'(arlen) + 1;
        r_addr = araddr;
        r_idx  = 0;
      end
      if (rready && r_rem > 0) begin
        rvalid = 1'b1;
        rdata  = rpat(r_addr + r_idx);
        rlast  = (r_rem == 1);
        r_rem--;
        r_idx++;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
      end
    end
  end

  // Requester write-data sources advance one word after each of their own accepted beats.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs_pend[0]) begin hs_pend[0] = 1'b0; wr_idx[0]++; req0_wdata = wbase(0) + wr_idx[0]; end
      if (hs_pend[1]) begin hs_pend[1] = 1'b0; wr_idx[1]++; req1_wdata = wbase(1) + wr_idx[1]; end
    end
  end

  task automatic monitor_cycle();
    txn_t        t;
    logic [31:0] e;
    logic        dn;
    chk("dual_ready", req0_ready & req1_ready, 0);
    if (req0_ready) owner = 0;
    else if (req1_ready) owner = 1;
    if (awvalid && awready) begin
      if (q_txn[owner].size() == 0) fail_now("aw_txn");
      else begin
        t = q_txn[owner][0];
        chk("awaddr", awaddr, t.addr);
        chk("awlen", awlen, t.len);
      end
    end
    if (arvalid && arready) begin
      if (q_txn[owner].size() == 0) fail_now("ar_txn");
      else begin
        t = q_txn[owner][0];
        chk("araddr", araddr, t.addr);
        chk("arlen", arlen, t.len);
      end
    end
    if (wvalid) begin
      chk("wready_mirror", (owner == 1) ? req1_wready : req0_wready, wready);
      chk("wready_other", (owner == 1) ? req0_wready : req1_wready, 0);
    end
    if (wvalid && wready) begin
      if (q_wd[owner].size() == 0) fail_now("wbeat_expected");
      else begin
        e = q_wd[owner].pop_front();
        chk("wdata", wdata, e);
        chk("wlast", wlast, bc[owner] == int'(q_txn[owner][0].len));
      end
      bc[owner]++;
      hs_pend[owner] = 1'b1;
    end
    if (req0_rvalid || req1_rvalid) begin
      chk("rvalid_other", (owner == 1) ? req0_rvalid : req1_rvalid, 0);
      if (q_rd[owner].size() == 0) fail_now("rbeat_expected");
      else begin
        e = q_rd[owner].pop_front();
        chk("rdata", (owner == 1) ? req1_rdata : req0_rdata, e);
        chk("rlast", (owner == 1) ? req1_rlast : req0_rlast, bc[owner] == int'(q_txn[owner][0].len));
      end
      bc[owner]++;
    end
    if (!rvalid) chk("rlast_idle", req0_rlast | req1_rlast, 0);
    for (int n = 0; n < 2; n++) begin
      dn = (n == 1) ? req1_done : req0_done;
      if (dn) begin
        if (n != owner || q_txn[n].size() == 0) fail_now("done_expected");
        else begin
          t = q_txn[n].pop_front();
          chk("resp", (n == 1) ? req1_resp : req0_resp, t.resp);
          chk("beats", bc[n], int'(t.len) + 1);
          if (q_order.size() == 0) fail_now("grant_order_entry");
          else chk("grant_order", n, q_order.pop_front());
        end
        bc[n] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) monitor_cycle();
    end
  end

  task automatic issue(input int n, input logic wr, input logic [31:0] addr,
                       input logic [7:0] len, input logic [1:0] resp);
    txn_t t;
    logic ok;
    t.wr = wr; t.addr = addr; t.len = len; t.resp = wr ? resp : 2'b00;
    q_txn[n].push_back(t);
    for (int i = 0; i <= int'(len); i++) begin
      if (wr) q_wd[n].push_back(wbase(n) + i);
      else    q_rd[n].push_back(rpat(addr + i));
    end
    wr_idx[n] = 0;
    if (n == 0) begin
      req0_write = wr; req0_addr = addr; req0_len = len; req0_wdata = wbase(0); req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = addr; req1_len = len; req1_wdata = wbase(1); req1_valid = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      #2;
      if ((n == 1) ? req1_ready : req0_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    chk("grant_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      #2;
      if (q_txn[0].size() == 0 && q_txn[1].size() == 0 && q_order.size() == 0) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valids"}, {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk({tag, "_req_out"}, {req0_rvalid, req1_rvalid, req0_wready, req1_wready, req0_done, req1_done}, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_resp"}, {req0_resp, req1_resp}, 0);
  endtask

  initial begin
    logic ok;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_len = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_len = '0; req1_wdata = '0;
    bc[0] = 0; bc[1] = 0; wr_idx[0] = 0; wr_idx[1] = 0; hs_pend[0] = 1'b0; hs_pend[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write from req0, slave answers bresp=01.
    sl_bresp = 2'b01;
    q_order.push_back(0);
    issue(0, 1'b1, 32'h10, 8'd3, 2'b01);
    wait_idle();

    // Single 8-beat read from req1.
    q_order.push_back(1);
    issue(1, 1'b0, 32'h20, 8'd7, 2'b00);
    wait_idle();

    // Simultaneous requests twice: expect grants 0,1,0,1.
    sl_bresp = 2'b10;
    for (int k = 0; k < 2; k++) begin
      q_order.push_back(0);
      q_order.push_back(1);
      fork
        issue(0, 1'b0, 32'h40 + k, 8'd1, 2'b00);
        issue(1, 1'b1, 32'h50 + k, 8'd2, 2'b10);
      join
      wait_idle();
    end

    // Maximum burst: 256 read beats.
    q_order.push_back(1);
    issue(1, 1'b0, 32'h100, 8'hFF, 2'b00);
    wait_idle();

    // Write with wready alternating every cycle.
    sl_bresp = 2'b11;
    w_toggle = 1'b1;
    q_order.push_back(0);
    issue(0, 1'b1, 32'h60, 8'd3, 2'b11);
    wait_idle();
    w_toggle = 1'b0;

    // Reset in the middle of a write burst; req0 last won so only reset restores req0 priority.
    issue(0, 1'b1, 32'h70, 8'd3, 2'b00);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      #2;
      if (bc[0] >= 2) ok = 1'b1;
    end
    chk("mid_burst_timeout", ok, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_txn[0].delete(); q_wd[0].delete(); q_rd[0].delete();
    bc[0] = 0; b_pend = 1'b0; r_rem = 0;
    @(negedge clk);
    #2;
    check_quiet("abort");
    @(posedge clk);
    #1;
    q_order.push_back(0);
    q_order.push_back(1);
    fork
      issue(0, 1'b0, 32'h80, 8'd0, 2'b00);
      issue(1, 1'b0, 32'h90, 8'd0, 2'b00);
    join
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width (word addressing); DATA_WIDTH, default 32, data width.
REQ-002 Ports SHALL be, in order: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-003 Requester ports, N in {0,1}, SHALL be: reqN_valid in 1 command pending; reqN_write in 1 1=write, 0=read; reqN_addr in ADDR_WIDTH start word; reqN_len in 8 beats-1.
REQ-004 reqN_ready out 1 command-accept pulse; reqN_wdata in DATA_WIDTH write beat; reqN_wready out 1 beat consumed.
REQ-005 reqN_rdata out DATA_WIDTH read beat; reqN_rvalid out 1 read beat valid; reqN_rlast out 1 last read beat.
REQ-006 reqN_done out 1 transaction-complete pulse; reqN_resp out 2 captured bresp (00 for reads).
REQ-007 AXI master ports SHALL be: awaddr out ADDR_WIDTH; awlen out 8; awvalid out 1; awready in 1; wdata out DATA_WIDTH; wvalid out 1; wready in 1; wlast out 1.
REQ-008 bresp in 2; bvalid in 1; bready out 1; araddr out ADDR_WIDTH; arlen out 8; arvalid out 1; arready in 1.
REQ-009 rdata in DATA_WIDTH; rvalid in 1; rready out 1; rlast in 1.

Function
REQ-010 The block SHALL share one AXI slave between two requesters, with one transaction outstanding at a time.
REQ-011 FSM states SHALL be IDLE, AW, W, B, AR, R, DONE.
REQ-012 In IDLE with any reqN_valid, the arbiter SHALL grant one requester, pulse its reqN_ready for that cycle, latch write/addr/len, and move to AW (write) or AR (read).
REQ-013 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; a lone requester is always granted.
REQ-014 A requester not granted SHALL hold reqN_valid and its fields stable until its reqN_ready.
REQ-015 AW SHALL drive awvalid=1, awaddr/awlen from the latched values, until the cycle awvalid&&awready, then go to W.
REQ-016 W SHALL drive wvalid=1 and wdata=reqG_wdata, where G is the granted requester.
REQ-017 In W, reqG_wready SHALL equal wready combinationally, and the beat counter SHALL increment on each wvalid&&wready.
REQ-018 In W, wlast SHALL be 1 when beat counter == latched len; exactly len+1 beats SHALL be sent; after the last handshake go to B.
REQ-019 B SHALL drive bready=1; on bvalid, capture bresp into reqG_resp, then go to DONE.
REQ-020 AR SHALL drive arvalid=1 with araddr/arlen until arvalid&&arready, then go to R.
REQ-021 R SHALL drive rready=1, with reqG_rvalid=rvalid, reqG_rdata=rdata and reqG_rlast=rlast combinationally; rvalid&&rlast SHALL move to DONE.
REQ-022 The non-granted requester's rvalid, rlast, wready and done SHALL be 0 at all times.
REQ-023 DONE SHALL last one cycle: pulse reqG_done, update the last-grant register to G, then return to IDLE.
REQ-024 Minimum turnaround SHALL be one IDLE cycle between transactions; a request pending in DONE is granted in the following IDLE.
REQ-025 The beat counter SHALL be 8 bits, cleared on grant; len=255 yields 256 beats without overflow error.
REQ-026 Any AXI ready or valid input outside its consuming state SHALL be ignored.
REQ-027 awvalid, wvalid, arvalid, bready and rready SHALL be 0 outside their own state.

Reset
REQ-028 On rst_n=0 at a clk edge, the FSM SHALL enter IDLE, clear the beat counter, and set last-grant=1 so requester 0 wins the first tie.
REQ-029 On reset, all registered outputs SHALL be 0, including reqN_resp and the AXI address and data outputs.
REQ-030 Reset mid-transaction SHALL abort without completing the transaction or pulsing done; no output SHALL be valid in the cycle after reset.

Verification
REQ-031 req0 write, addr=0x10, len=3, awready immediate, wready=1 -> 4 beats with wlast on the 4th; bresp=01 -> req0_resp=01, one req0_done pulse.
REQ-032 req1 read, addr=0x20, len=7, slave returns 8 beats with rlast on the 8th -> req1_rvalid 8 times, req1_rlast once, req0 outputs stay 0.
REQ-033 req0 and req1 valid together after reset -> req0 granted first, req1 next; repeat both -> alternation 0,1,0,1.
REQ-034 Write with wready toggling 1,0,1,0 -> req0_wready mirrors wready, 4 beats total, and the counter does not advance on stalls.
REQ-035 rst_n=0 during W after 2 of 4 beats -> next cycle all valids 0, state IDLE, no done; a new request is then granted by req0-priority.
